ifid_fetch: RTL and testbench
=============================

Name: ifid_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the hazard detection unit.
- Owns the PC and drives the instruction-memory request.
- Consumes PCWrite/IFIDWrite/Hazard/imem_en from the hazard unit and redirects from branch resolution.
- Produces the IF/ID instruction that the hazard unit inspects as Instr.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP_INSTR, 32'h00000000, encoding injected into IF/ID on flush/bubble

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  global run enable; 0 freezes all state
- PCWrite  in  1  hazard unit: PC may advance
- IFIDWrite  in  1  hazard unit: IF/ID may load
- Hazard  in  1  hazard unit: bubble request
- imem_en  in  1  hazard unit: fetch permitted this cycle
- branch_taken  in  1  branch resolved taken this cycle
- branch_target  in  32  redirect address, word aligned
- imem_wait  in  1  instruction memory not ready
- imem_rdata  in  32  fetched instruction, valid when imem_rd=1 and imem_wait=0
- imem_addr  out  32  fetch address (= PC)
- imem_rd  out  1  fetch request
- IFIDInstr  out  32  instruction to ID stage / hazard unit
- IFIDPCPlus4  out  32  PC+4 of IFIDInstr
- IFIDValid  out  1  1 = IFIDInstr is a real instruction, 0 = bubble

Behaviour:
- Reset (rst=1 at edge, overrides everything):
  - PC=RESET_PC, IFIDInstr=NOP_INSTR, IFIDPCPlus4=RESET_PC+4, IFIDValid=0
  - pending redirect cleared; FSM=RUN
- Combinational outputs: imem_addr=PC (or pending target when one is latched); imem_rd = enable & imem_en & state!=FLUSH.
- FSM states: RUN, WAIT, FLUSH.
  - RUN→WAIT when imem_rd & imem_wait.
  - WAIT→RUN when imem_wait=0.
  - any state→FLUSH on branch_taken (accepted per redirect rules below).
  - FLUSH→RUN after exactly one cycle.
- PC update (enable=1, imem_wait=0, state!=FLUSH):
  - branch_taken → PC=branch_target
  - else if pending redirect → PC=pending target, pending cleared
  - else if PCWrite → PC=PC+4, wraps modulo 2^32
  - else hold
- IF/ID update (enable=1):
  - branch_taken or state=FLUSH → IFIDInstr=NOP_INSTR, IFIDValid=0 (flush takes priority over IFIDWrite)
  - else IFIDWrite & !imem_wait & imem_rd → IFIDInstr=imem_rdata, IFIDPCPlus4=PC+4, IFIDValid=1
  - else IFIDWrite & !Hazard & (imem_wait | !imem_rd) → bubble: NOP_INSTR, IFIDValid=0
  - else (IFIDWrite=0) → hold all IF/ID fields
- Redirect during wait: branch_taken while imem_wait=1 latches branch_target into the pending register; PC is unchanged. In-flight data returned is discarded (not loaded into IF/ID). Redirect is applied on the first cycle with imem_wait=0.
- A second branch_taken while pending overwrites the pending target (last wins).
- enable=0: no state changes; imem_rd=0; outputs hold.
- Fetch latency: an instruction at PC appears on IFIDInstr one cycle after the accepting edge. Taken branch costs exactly 1 bubble (FLUSH).
- Low 2 bits of branch_target are ignored; PC[1:0] forced to 0.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0, wrap modulo 2^32.
  - fetch_count increments on each IF/ID load with IFIDValid=1.
  - stall_count increments each enabled cycle where PC holds (PCWrite=0 or imem_wait=1).
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then enable=1, PCWrite=IFIDWrite=imem_en=1, imem_wait=0, rdata=0x20080005 → cycle1 IFIDInstr=0x20080005, IFIDPCPlus4=0x4, IFIDValid=1, PC=0x4.
- IFIDWrite=0, PCWrite=0, Hazard=1 for 2 cycles → PC and IFIDInstr hold; imem_addr unchanged.
- branch_taken=1, target=0x100 with imem_wait=0 → next cycle PC=0x100, IFIDValid=0, IFIDInstr=0x0; following cycle imem_addr=0x100.
- imem_wait=1 for 3 cycles, branch_taken pulse target=0x40 in cycle 2 → PC stays; after wait drops PC=0x40, stale data never appears in IF/ID.
- PC=0xFFFFFFFC, PCWrite=1 → PC=0x00000000, IFIDPCPlus4=0x00000000.
- rst asserted mid-WAIT → next edge PC=RESET_PC, IFIDValid=0, FSM=RUN, pending cleared; with FETCH_PERF_CNT_EN, counters=0.

Source files
------------

// File: rtl/ifid_fetch.sv
// Instruction fetch stage with PC, redirect buffer and IF/ID register.
// Ports: clk/rst (sync, active-high), enable, hazard-unit controls
// (PCWrite, IFIDWrite, Hazard, imem_en), branch_taken/branch_target,
// imem_wait/imem_rdata in; imem_addr/imem_rd, IFIDInstr, IFIDPCPlus4,
// IFIDValid out. Define FETCH_PERF_CNT_EN to add fetch_count and
// stall_count outputs.
module ifid_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        Hazard,
  input  logic        imem_en,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_wait,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  output logic [31:0] IFIDInstr,
  output logic [31:0] IFIDPCPlus4,
  output logic        IFIDValid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic [31:0] tgt;
  logic        flushing;
  logic        adv;
  logic        discard;
  logic        load;

  assign tgt      = {branch_target[31:2], 2'b00};
  assign flushing = (state_q == S_FLUSH);
  // PC may only move when memory is ready and no flush is in progress
  assign adv      = enable & ~imem_wait & ~flushing;
  // a buffered redirect is being applied: returned data is stale
  assign discard  = adv & pend_vld_q;
  assign load     = IFIDWrite & ~imem_wait & imem_rd;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (enable) begin
      if (branch_taken & ~imem_wait) begin
        state_d = S_FLUSH;
      end else begin
        case (state_q)
          S_RUN:   if (imem_rd & imem_wait) state_d = S_WAIT;
          S_WAIT:  if (!imem_wait) state_d = S_RUN;
          S_FLUSH: state_d = S_RUN;
          default: state_d = S_RUN;
        endcase
      end
    end
  end

  // output logic
  always_comb begin
    imem_rd   = enable & imem_en & ~flushing;
    imem_addr = pend_vld_q ? pend_q : pc_q;
  end

  // PC, redirect buffer and IF/ID next values
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    instr_d    = instr_q;
    pcp4_d     = pcp4_q;
    valid_d    = valid_q;
    if (enable) begin
      if (adv) begin
        if (branch_taken) begin
          pc_d       = tgt;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          pc_d       = pend_q;
          pend_vld_d = 1'b0;
        end else if (PCWrite) begin
          pc_d = pc_q + 32'd4;
        end
      end else if (branch_taken) begin
        // redirect arrives while PC is frozen: last one wins
        pend_d     = tgt;
        pend_vld_d = 1'b1;
      end

      if (branch_taken | flushing | discard) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else if (load) begin
        instr_d = imem_rdata;
        pcp4_d  = pc_q + 32'd4;
        valid_d = 1'b1;
      end else if (IFIDWrite & ~Hazard) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_q     <= RESET_PC;
      pend_vld_q <= 1'b0;
      instr_q    <= NOP_INSTR;
      pcp4_q     <= RESET_PC + 32'd4;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      instr_q    <= instr_d;
      pcp4_q     <= pcp4_d;
      valid_q    <= valid_d;
    end
  end

  assign IFIDInstr   = instr_q;
  assign IFIDPCPlus4 = pcp4_q;
  assign IFIDValid   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] scnt_q, scnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    scnt_d = scnt_q;
    if (enable & ~(branch_taken | flushing | discard) & load)
      fcnt_d = fcnt_q + 32'd1;
    if (enable & (~PCWrite | imem_wait))
      scnt_d = scnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= 32'd0;
      scnt_q <= 32'd0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign fetch_count = fcnt_q;
  assign stall_count = scnt_q;
`endif

endmodule

// File: tb/tb_ifid_fetch.sv
// Scoreboard bench for ifid_fetch.
// Expected IF/ID and fetch outputs are queued per driven cycle.
module tb_ifid_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        Hazard;
  logic        imem_en;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_wait;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] IFIDInstr;
  logic [31:0] IFIDPCPlus4;
  logic        IFIDValid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  ifid_fetch dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .PCWrite(PCWrite),
    .IFIDWrite(IFIDWrite),
    .Hazard(Hazard),
    .imem_en(imem_en),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_wait(imem_wait),
    .imem_rdata(imem_rdata),
    .imem_addr(imem_addr),
    .imem_rd(imem_rd),
    .IFIDInstr(IFIDInstr),
    .IFIDPCPlus4(IFIDPCPlus4),
    .IFIDValid(IFIDValid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic [31:0] addr;
    logic        rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  task automatic drv(input logic en, input logic pcw,
                     input logic ifw, input logic hz,
                     input logic ie, input logic bt,
                     input logic [31:0] tg, input logic wt,
                     input logic [31:0] rd);
    enable        = en;
    PCWrite       = pcw;
    IFIDWrite     = ifw;
    Hazard        = hz;
    imem_en       = ie;
    branch_taken  = bt;
    branch_target = tg;
    imem_wait     = wt;
    imem_rdata    = rd;
  endtask

  task automatic cyc(input string tag,
                     input logic [31:0] e_instr,
                     input logic [31:0] e_pcp4,
                     input logic e_valid,
                     input logic [31:0] e_addr,
                     input logic e_rd);
    exp_t e;
    e.tag = tag;
    e.instr = e_instr;
    e.pcp4 = e_pcp4;
    e.valid = e_valid;
    e.addr = e_addr;
    e.rd = e_rd;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_instr"}, IFIDInstr, e.instr);
      check({e.tag, "_pcp4"}, IFIDPCPlus4, e.pcp4);
      check({e.tag, "_valid"}, {31'd0, IFIDValid},
            {31'd0, e.valid});
      check({e.tag, "_addr"}, imem_addr, e.addr);
      check({e.tag, "_rd"}, {31'd0, imem_rd},
            {31'd0, e.rd});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    cyc("reset", 32'h0, 32'h4, 0, 32'h0, 0);
    rst = 1'b0;

    drv(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'h20080005);
    cyc("fetch0", 32'h20080005, 32'h4, 1, 32'h4, 1);
    imem_rdata = 32'h11111111;
    cyc("fetch1", 32'h11111111, 32'h8, 1, 32'h8, 1);

    drv(1, 0, 0, 1, 1, 0, 32'h0, 0, 32'h22222222);
    cyc("stall0", 32'h11111111, 32'h8, 1, 32'h8, 1);
    cyc("stall1", 32'h11111111, 32'h8, 1, 32'h8, 1);

    drv(0, 1, 1, 0, 1, 0, 32'h0, 0, 32'h33333333);
    cyc("disabled", 32'h11111111, 32'h8, 1, 32'h8, 0);

    drv(1, 1, 1, 0, 1, 1, 32'h103, 0, 32'h33333333);
    cyc("br_taken", 32'h0, 32'h8, 0, 32'h100, 0);
    drv(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'h44444444);
    cyc("br_flush", 32'h0, 32'h8, 0, 32'h100, 1);
    imem_rdata = 32'h55555555;
    cyc("br_fetch", 32'h55555555, 32'h104, 1, 32'h104, 1);

    drv(1, 0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc("bubble", 32'h0, 32'h104, 0, 32'h104, 0);

    drv(1, 1, 1, 0, 1, 0, 32'h0, 1, 32'hDEADBEEF);
    cyc("wait0", 32'h0, 32'h104, 0, 32'h104, 1);
    drv(1, 1, 1, 0, 1, 1, 32'h40, 1, 32'hDEADBEEF);
    cyc("wait_br", 32'h0, 32'h104, 0, 32'h40, 1);
    drv(1, 1, 1, 0, 1, 0, 32'h0, 1, 32'hDEADBEEF);
    cyc("wait2", 32'h0, 32'h104, 0, 32'h40, 1);
    drv(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'hBADBAD00);
    cyc("wait_end", 32'h0, 32'h104, 0, 32'h40, 1);
    imem_rdata = 32'h66666666;
    cyc("redir_fetch", 32'h66666666, 32'h44, 1, 32'h44, 1);

    drv(1, 1, 1, 0, 1, 1, 32'hFFFFFFFC, 0, 32'h0);
    cyc("wrap_br", 32'h0, 32'h44, 0, 32'hFFFFFFFC, 0);
    branch_taken = 1'b0;
    cyc("wrap_flush", 32'h0, 32'h44, 0, 32'hFFFFFFFC, 1);
    imem_rdata = 32'h77777777;
    cyc("wrap_fetch", 32'h77777777, 32'h0, 1, 32'h0, 1);

    drv(1, 1, 1, 0, 1, 0, 32'h0, 1, 32'hDEAD0001);
    cyc("lw_wait", 32'h0, 32'h0, 0, 32'h0, 1);
    drv(1, 1, 1, 0, 1, 1, 32'h200, 1, 32'hDEAD0002);
    cyc("lw_br1", 32'h0, 32'h0, 0, 32'h200, 1);
    drv(1, 1, 1, 0, 1, 1, 32'h300, 1, 32'hDEAD0003);
    cyc("lw_br2", 32'h0, 32'h0, 0, 32'h300, 1);
    drv(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'hDEAD0004);
    cyc("lw_apply", 32'h0, 32'h0, 0, 32'h300, 1);
    imem_rdata = 32'h88888888;
    cyc("lw_fetch", 32'h88888888, 32'h304, 1, 32'h304, 1);

    drv(1, 1, 1, 0, 1, 0, 32'h0, 1, 32'hDEAD0005);
    cyc("rw_wait", 32'h0, 32'h304, 0, 32'h304, 1);
    drv(1, 1, 1, 0, 1, 1, 32'h500, 1, 32'hDEAD0006);
    cyc("rw_br", 32'h0, 32'h304, 0, 32'h500, 1);
    rst = 1'b1;
    branch_taken = 1'b0;
    cyc("rw_reset", 32'h0, 32'h4, 0, 32'h0, 1);
    rst = 1'b0;
    drv(1, 1, 1, 0, 1, 0, 32'h0, 0, 32'h99999999);
    cyc("rw_fetch", 32'h99999999, 32'h4, 1, 32'h4, 1);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'd1);
    check("stall_count", stall_count, 32'd0);
`endif

    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
